exception_ctrl: RTL and testbench

- Consumes the main decoder's NotAnInstr and ERet flags, plus an external interrupt line.
- Sequences exception entry and return for the LEGv8 core: saves the faulting or interrupted PC (ELR) and a syndrome (ESR), then redirects fetch to the handler vector.
- Squashes the instruction in decode on entry.
- Provides the system-register read data used by MRS.

---
 rtl/exception_ctrl_if.sv | 29 ++
 rtl/exception_ctrl.sv | 118 +++++++++++
 tb/tb_exception_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/exception_ctrl_if.sv
// rtl/exception_ctrl_if.sv - decoder/fetch/system-register bundle for the exception controller
interface exception_ctrl_if #(
    parameter int DW    = 64,
    parameter int ESR_W = 4
);
    logic             instr_valid;
    logic             not_an_instr;
    logic             eret;
    logic             ext_irq;
    logic [DW-1:0]    pc_decode;
    logic [1:0]       mrs_sel;
    logic             redirect;
    logic [DW-1:0]    redirect_pc;
    logic             flush;
    logic             in_handler;
    logic [DW-1:0]    elr;
    logic [ESR_W-1:0] esr;
    logic [DW-1:0]    mrs_data;

    modport master (
        output instr_valid, not_an_instr, eret, ext_irq, pc_decode, mrs_sel,
        input  redirect, redirect_pc, flush, in_handler, elr, esr, mrs_data
    );

    modport slave (
        input  instr_valid, not_an_instr, eret, ext_irq, pc_decode, mrs_sel,
        output redirect, redirect_pc, flush, in_handler, elr, esr, mrs_data
    );
endinterface

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - LEGv8 exception entry/return sequencer with ELR/ESR and MRS read port
module exception_ctrl #(
    parameter int            DW          = 64,
    parameter logic [DW-1:0] VECTOR_ADDR = 'hD8,
    parameter int            ESR_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    exception_ctrl_if.slave   bus
);
    localparam logic [ESR_W-1:0] ESR_UNDEF = ESR_W'(1);
    localparam logic [ESR_W-1:0] ESR_IRQ   = ESR_W'(2);
    localparam logic [ESR_W-1:0] ESR_ERET  = ESR_W'(4);
    localparam logic [ESR_W-1:0] ESR_NEST  = ESR_W'(8);

    typedef enum logic [1:0] {RUN, TAKE, HANDLER, RETURN} state_t;

    state_t           state;
    logic [DW-1:0]    elr_q;
    logic [ESR_W-1:0] esr_q;
    logic             sync1, sync2, sync2_d;
    logic             irq_pending;
    logic             redirect_q, flush_q, in_handler_q;
    logic [DW-1:0]    redirect_pc_q;

    logic irq_rise;
    logic take_irq;

    assign irq_rise = sync2 & ~sync2_d;
    // Faults in decode win over the interrupt, which simply stays pending.
    assign take_irq = (state == RUN) && bus.instr_valid && !bus.not_an_instr
                      && !bus.eret && irq_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            elr_q         <= '0;
            esr_q         <= '0;
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            sync2_d       <= 1'b0;
            irq_pending   <= 1'b0;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            in_handler_q  <= 1'b0;
        end else begin
            sync1   <= bus.ext_irq;
            sync2   <= sync1;
            sync2_d <= sync2;
            // A fresh request arriving as the old one is taken must not be lost.
            if (irq_rise)
                irq_pending <= 1'b1;
            else if (take_irq)
                irq_pending <= 1'b0;

            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;

            case (state)
                RUN: begin
                    if (bus.instr_valid && (bus.not_an_instr || bus.eret || irq_pending)) begin
                        elr_q         <= bus.pc_decode;
                        esr_q         <= bus.not_an_instr ? ESR_UNDEF :
                                         bus.eret         ? ESR_ERET  : ESR_IRQ;
                        state         <= TAKE;
                        redirect_q    <= 1'b1;
                        flush_q       <= 1'b1;
                        redirect_pc_q <= VECTOR_ADDR;
                        in_handler_q  <= 1'b0;
                    end
                end
                TAKE: begin
                    state        <= HANDLER;
                    in_handler_q <= 1'b1;
                end
                HANDLER: begin
                    if (bus.instr_valid && bus.not_an_instr) begin
                        esr_q         <= ESR_NEST;
                        state         <= TAKE;
                        redirect_q    <= 1'b1;
                        flush_q       <= 1'b1;
                        redirect_pc_q <= VECTOR_ADDR;
                        in_handler_q  <= 1'b0;
                    end else if (bus.instr_valid && bus.eret) begin
                        state         <= RETURN;
                        redirect_q    <= 1'b1;
                        flush_q       <= 1'b1;
                        redirect_pc_q <= elr_q;
                    end
                end
                RETURN: begin
                    state        <= RUN;
                    in_handler_q <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        bus.mrs_data = '0;
        case (bus.mrs_sel)
            2'd0:    bus.mrs_data = elr_q;
            2'd1:    bus.mrs_data = {{(DW-ESR_W){1'b0}}, esr_q};
            2'd2:    bus.mrs_data = {{(DW-2){1'b0}}, irq_pending, in_handler_q};
            default: bus.mrs_data = '0;
        endcase
    end

    assign bus.redirect    = redirect_q;
    assign bus.flush       = flush_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.in_handler  = in_handler_q;
    assign bus.elr         = elr_q;
    assign bus.esr         = esr_q;
endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - directed and random checks of exception_ctrl against a behavioural model
module tb_exception_ctrl;
    localparam logic [63:0] VEC = 64'hD8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exception_ctrl_if #(.DW(64), .ESR_W(4)) bus ();

    exception_ctrl #(.DW(64), .VECTOR_ADDR(VEC), .ESR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: whether the core runs handler code, whether a redirect pulse is
    // being emitted this cycle and where to, plus the visible registers.
    bit          m_handler, m_pulse, m_pend;
    logic [63:0] m_target, m_elr;
    logic [3:0]  m_esr;
    bit          irq_hist [3];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_mrs(logic [1:0] sel);
        case (sel)
            2'd0:    return m_elr;
            2'd1:    return {60'd0, m_esr};
            2'd2:    return {62'd0, m_pend, m_handler};
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_edge();
        bit iv, nai, er, rise, taken;
        iv = bus.instr_valid; nai = bus.not_an_instr; er = bus.eret;
        if (reset) begin
            m_handler = 0; m_pulse = 0; m_pend = 0;
            m_target = 0; m_elr = 0; m_esr = 0;
            irq_hist = '{0, 0, 0};
            return;
        end
        rise  = irq_hist[1] && !irq_hist[2];
        taken = 0;
        if (m_pulse) begin
            // A pulse to the vector lands in the handler; a pulse elsewhere is a return.
            m_handler = (m_target == VEC) && !m_handler;
            m_pulse   = 0;
            m_target  = 0;
        end else if (!m_handler) begin
            if (iv && (nai || er || m_pend)) begin
                m_elr    = bus.pc_decode;
                m_esr    = nai ? 4'd1 : (er ? 4'd4 : 4'd2);
                taken    = !nai && !er;
                m_pulse  = 1;
                m_target = VEC;
            end
        end else if (iv && nai) begin
            m_esr     = 4'd8;
            m_pulse   = 1;
            m_target  = VEC;
            m_handler = 0;
        end else if (iv && er) begin
            m_pulse  = 1;
            m_target = m_elr;
        end
        if (rise) m_pend = 1;
        else if (taken) m_pend = 0;
        irq_hist[2] = irq_hist[1];
        irq_hist[1] = irq_hist[0];
        irq_hist[0] = bus.ext_irq;
    endtask

    task automatic check_all(string tag);
        chk({tag, ".redirect"},    {63'd0, bus.redirect},   {63'd0, m_pulse});
        chk({tag, ".flush"},       {63'd0, bus.flush},      {63'd0, m_pulse});
        chk({tag, ".redirect_pc"}, bus.redirect_pc,         m_pulse ? m_target : 64'd0);
        chk({tag, ".in_handler"},  {63'd0, bus.in_handler}, {63'd0, m_handler});
        chk({tag, ".elr"},         bus.elr,                 m_elr);
        chk({tag, ".esr"},         {60'd0, bus.esr},        {60'd0, m_esr});
        chk({tag, ".mrs"},         bus.mrs_data,            exp_mrs(bus.mrs_sel));
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(bit iv, bit nai, bit er, logic [63:0] pc);
        bus.instr_valid = iv; bus.not_an_instr = nai; bus.eret = er; bus.pc_decode = pc;
    endtask

    initial begin
        int n;
        bit found;
        reset = 1; drive(0, 0, 0, 0); bus.ext_irq = 0; bus.mrs_sel = 0;
        step("reset");
        step("reset2");
        reset = 0;
        step("idle");

        drive(1, 1, 0, 64'h40);
        step("undef");
        chk("undef.pc_const", bus.redirect_pc, 64'hD8);
        chk("undef.elr_const", bus.elr, 64'h40);
        drive(0, 0, 0, 64'h44);
        step("undef.handler");
        chk("undef.in_handler_const", {63'd0, bus.in_handler}, 64'd1);
        drive(1, 0, 1, 64'h1000);
        step("eret");
        chk("eret.pc_const", bus.redirect_pc, 64'h40);
        drive(0, 0, 0, 0);
        step("eret.run");

        drive(1, 0, 0, 64'h100);
        bus.ext_irq = 1;
        n = 0; found = 0;
        while (!found && n < 10) begin
            step("irq.wait");
            n++;
            found = bus.redirect;
        end
        chk("irq.seen", {63'd0, found}, 64'd1);
        chk("irq.latency_ge3", {63'd0, n >= 3}, 64'd1);
        chk("irq.esr_const", {60'd0, bus.esr}, 64'd2);
        bus.mrs_sel = 2; #1;
        chk("irq.pending_cleared", bus.mrs_data, 64'd0);
        drive(0, 0, 0, 0);
        step("irq.handler");
        drive(1, 0, 1, 0);
        step("irq.eret");
        drive(0, 0, 0, 0);
        step("irq.run");

        bus.ext_irq = 0;
        repeat (3) step("both.low");
        bus.ext_irq = 1;
        repeat (4) step("both.rise");
        chk("both.pending", bus.mrs_data, 64'd2);
        drive(1, 1, 0, 64'h80);
        step("both.fault");
        chk("both.esr_const", {60'd0, bus.esr}, 64'd1);
        drive(0, 0, 0, 0);
        step("both.handler");
        drive(1, 0, 1, 64'h200);
        step("both.eret");
        drive(1, 0, 0, 64'h84);
        step("both.return");
        step("both.irq");
        chk("both.irq_esr_const", {60'd0, bus.esr}, 64'd2);
        drive(0, 0, 0, 0);
        step("both.handler2");
        drive(1, 0, 1, 0);
        step("both.eret2");
        drive(0, 0, 0, 0);
        step("both.run");

        bus.mrs_sel = 1;
        drive(1, 0, 1, 64'h20);
        step("illeret");
        chk("illeret.esr_const", {60'd0, bus.esr}, 64'd4);
        drive(0, 0, 0, 0);
        step("illeret.handler");
        drive(1, 1, 0, 64'h44);
        step("nested");
        chk("nested.elr_const", bus.elr, 64'h20);
        chk("nested.esr_const", {60'd0, bus.esr}, 64'd8);
        drive(0, 0, 0, 0);
        step("nested.handler");
        drive(1, 0, 1, 0);
        step("nested.eret");
        drive(0, 0, 0, 0);
        step("nested.run");

        drive(1, 1, 0, 64'h300);
        step("rst.take");
        drive(0, 0, 0, 0);
        reset = 1;
        step("rst.mid_take");
        reset = 0;
        for (int s = 0; s < 3; s++) begin
            bus.mrs_sel = 2'(s); #1;
            chk("rst.mrs_zero", bus.mrs_data, 64'd0);
        end
        step("rst.after");

        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) == 0, {$urandom, $urandom} & ~64'h3);
            if ($urandom_range(0, 19) == 0) bus.ext_irq = ~bus.ext_irq;
            bus.mrs_sel = 2'($urandom_range(0, 3));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
